dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory with combinational read.
// m0 (CPU) has priority; m1 (PDU) is promoted for one cycle after STARVE_MAX consecutive denials.
module dmem_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic [15:0]       m0_gcnt,
   output logic [15:0]       m1_gcnt
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } own_e;

   own_e              own_q, own_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              m0_rvalid_q, m0_rvalid_d;
   logic              m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic [15:0]       m0_gcnt_q, m0_gcnt_d;
   logic [15:0]       m1_gcnt_q, m1_gcnt_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      if (en && (v != 16'hFFFF)) begin
         sat_inc16 = v + 16'd1;
      end else begin
         sat_inc16 = v;
      end
   endfunction

   // Grant selection; reset suppresses every grant so nothing reaches memory
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (rst) begin
         if (m1_req && (starve_q == STARVE_LIM)) begin
            m1_gnt = 1'b1;
         end else if (m0_req) begin
            m0_gnt = 1'b1;
         end else if (m1_req) begin
            m1_gnt = 1'b1;
         end else begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
         end
      end else begin
         m0_gnt = 1'b0;
         m1_gnt = 1'b0;
      end
   end

   // Memory port mux; idle port is driven to all zeros
   always_comb begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_we    = 1'b0;
      mem_wdata = {DATA_W{1'b0}};
      if (m0_gnt) begin
         mem_addr  = m0_addr;
         mem_we    = m0_we;
         mem_wdata = m0_wdata;
      end else if (m1_gnt) begin
         mem_addr  = m1_addr;
         mem_we    = m1_we;
         mem_wdata = m1_wdata;
      end else begin
         mem_addr  = {ADDR_W{1'b0}};
         mem_we    = 1'b0;
         mem_wdata = {DATA_W{1'b0}};
      end
   end

   // Next-state for owner FSM, starvation counter, read return and grant counters
   always_comb begin
      own_d       = OWN_NONE;
      starve_d    = {SW{1'b0}};
      m0_rvalid_d = m0_gnt & ~m0_we;
      m1_rvalid_d = m1_gnt & ~m1_we;
      m0_rdata_d  = m0_rdata_q;
      m1_rdata_d  = m1_rdata_q;
      m0_gcnt_d   = sat_inc16(m0_gcnt_q, m0_gnt);
      m1_gcnt_d   = sat_inc16(m1_gcnt_q, m1_gnt);

      case ({m1_gnt, m0_gnt})
         2'b01:   own_d = OWN_M0;
         2'b10:   own_d = OWN_M1;
         default: own_d = OWN_NONE;
      endcase

      if (m1_req && !m1_gnt) begin
         if (starve_q == STARVE_LIM) begin
            starve_d = starve_q;
         end else begin
            starve_d = starve_q + SW'(1);
         end
      end else begin
         starve_d = {SW{1'b0}};
      end

      if (m0_rvalid_d) begin
         m0_rdata_d = mem_rdata;
      end else begin
         m0_rdata_d = m0_rdata_q;
      end
      if (m1_rvalid_d) begin
         m1_rdata_d = mem_rdata;
      end else begin
         m1_rdata_d = m1_rdata_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         own_q       <= OWN_NONE;
         starve_q    <= {SW{1'b0}};
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= {DATA_W{1'b0}};
         m1_rdata_q  <= {DATA_W{1'b0}};
         m0_gcnt_q   <= 16'd0;
         m1_gcnt_q   <= 16'd0;
      end else begin
         own_q       <= own_d;
         starve_q    <= starve_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         m0_gcnt_q   <= m0_gcnt_d;
         m1_gcnt_q   <= m1_gcnt_d;
      end
   end

   // A read launched just before reset must not surface while reset is held
   assign m0_rvalid = m0_rvalid_q & rst;
   assign m1_rvalid = m1_rvalid_q & rst;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign owner     = own_q;
   assign m0_gcnt   = m0_gcnt_q;
   assign m1_gcnt   = m1_gcnt_q;

endmodule
